// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, coordinate type and window decode helper.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COORD_MAX = 1 << COORD_W;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= v < lo+len.
  function automatic logic in_window(input coord_t v, input int unsigned lo,
                                     input int unsigned len);
    return (32'(v) >= lo) && (32'(v) < (lo + len));
  endfunction

endpackage

// File: rtl/pix_en_gen.sv
// Pixel clock-enable generator: divides clk by DIV and emits a one-cycle advance strobe.
module pix_en_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  output logic adv
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if ((DIV < 1) || (DIV > 16)) begin : g_bad_div
    $error("pix_en_gen: DIV must be in 1..16");
  end

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             wrap_c;

  // Next divider count; the strobe fires on the enabled cycle that wraps the count.
  always_comb begin
    wrap_c    = (div_cnt_q == CNT_LAST);
    div_cnt_d = div_cnt_q;
    adv       = 1'b0;
    if (en) begin
      div_cnt_d = wrap_c ? '0 : div_cnt_q + CNT_W'(1);
      adv       = wrap_c;
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan sequencer: pixel enable, scan counters, sync/blank decode and line/frame markers.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned DIV       = 2,
  parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               en,
  output logic               pix_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam coord_t      X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam coord_t      Y_LAST   = COORD_W'(V_TOTAL - 1);

  if ((H_TOTAL > COORD_MAX) || (V_TOTAL > COORD_MAX)) begin : g_bad_timing
    $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic   adv;
  coord_t x_q, x_d, y_q, y_d;
  logic   pix_tick_q, pix_tick_d;
  logic   line_start_q, line_start_d;
  logic   frame_start_q, frame_start_d;
  logic   video_on_q, video_on_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;

  pix_en_gen #(
    .DIV(DIV)
  ) u_pix_en (
    .clk  (clk),
    .clr_n(clr_n),
    .en   (en),
    .adv  (adv)
  );

  // Next scan position; every output is decoded from it so outputs line up with x/y.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    pix_tick_d    = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (adv) begin
      pix_tick_d = 1'b1;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
      line_start_d  = (x_d == '0);
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
    video_on_d = (32'(x_d) < H_DISPLAY) && (32'(y_d) < V_DISPLAY);
    hsync_d    = in_window(x_d, HS_START, H_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = in_window(y_d, VS_START, V_SYNC) ? SYNC_POL : ~SYNC_POL;
  end

  // Scan and output registers; reset parks at the last pixel so the first advance is (0,0).
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pix_tick    = pix_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: three configurations checked every cycle against a pixel-count model.
module tb_vga_timing_ctrl;

  typedef struct {
    int hd, hf, hs, hb;
    int vd, vf, vs, vb;
    int div;
    bit pol;
  } cfg_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_tick;
    logic       line_start;
    logic       frame_start;
    logic       video_on;
    logic       hsync;
    logic       vsync;
  } obs_t;

  typedef struct {
    logic clr_n;
    logic en;
    obs_t exp;
  } vec_t;

  logic       clk;
  logic       clr_n_v [3];
  logic       en_v    [3];
  logic       pt      [3];
  logic       hs      [3];
  logic       vs      [3];
  logic       vo      [3];
  logic       ls      [3];
  logic       fs      [3];
  logic [9:0] xs      [3];
  logic [9:0] ys      [3];

  cfg_t cfg [3];
  int   e   [3];
  bit   adv [3];
  int   total, bad, cyc;

  vga_timing_ctrl #(.DIV(2)) dut_a (
    .clk(clk), .clr_n(clr_n_v[0]), .en(en_v[0]), .pix_tick(pt[0]), .hsync(hs[0]),
    .vsync(vs[0]), .video_on(vo[0]), .x(xs[0]), .y(ys[0]), .line_start(ls[0]),
    .frame_start(fs[0]));

  vga_timing_ctrl #(.DIV(1)) dut_b (
    .clk(clk), .clr_n(clr_n_v[1]), .en(en_v[1]), .pix_tick(pt[1]), .hsync(hs[1]),
    .vsync(vs[1]), .video_on(vo[1]), .x(xs[1]), .y(ys[1]), .line_start(ls[1]),
    .frame_start(fs[1]));

  vga_timing_ctrl #(
    .DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)
  ) dut_c (
    .clk(clk), .clr_n(clr_n_v[2]), .en(en_v[2]), .pix_tick(pt[2]), .hsync(hs[2]),
    .vsync(vs[2]), .video_on(vo[2]), .x(xs[2]), .y(ys[2]), .line_start(ls[2]),
    .frame_start(fs[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: e enabled clocks since reset -> e/DIV pixels shown; pixel n sits at raster index n-1.
  function automatic obs_t model(input cfg_t c, input int ecnt, input bit a);
    obs_t o;
    int ht, vt, k, p, px, py;
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    k  = ecnt / c.div;
    if (k == 0) begin
      px = ht - 1;
      py = vt - 1;
    end else begin
      p  = (k - 1) % (ht * vt);
      px = p % ht;
      py = p / ht;
    end
    o.x           = 10'(px);
    o.y           = 10'(py);
    o.pix_tick    = a;
    o.line_start  = a && (px == 0);
    o.frame_start = a && (px == 0) && (py == 0);
    o.video_on    = (px < c.hd) && (py < c.vd);
    o.hsync       = ((px >= c.hd + c.hf) && (px < c.hd + c.hf + c.hs)) ? c.pol : ~c.pol;
    o.vsync       = ((py >= c.vd + c.vf) && (py < c.vd + c.vf + c.vs)) ? c.pol : ~c.pol;
    return o;
  endfunction

  function automatic obs_t mk(input int px, input int py, input bit p_t, input bit l_s,
                              input bit f_s, input bit v_o, input bit h_s, input bit v_s);
    obs_t o;
    o.x = 10'(px); o.y = 10'(py);
    o.pix_tick = p_t; o.line_start = l_s; o.frame_start = f_s;
    o.video_on = v_o; o.hsync = h_s; o.vsync = v_s;
    return o;
  endfunction

  function automatic obs_t get_obs(input int i);
    obs_t o;
    o.x = xs[i]; o.y = ys[i];
    o.pix_tick = pt[i]; o.line_start = ls[i]; o.frame_start = fs[i];
    o.video_on = vo[i]; o.hsync = hs[i]; o.vsync = vs[i];
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("x=%0d y=%0d pt=%b ls=%b fs=%b vo=%b hs=%b vs=%b", o.x, o.y,
                     o.pix_tick, o.line_start, o.frame_start, o.video_on, o.hsync, o.vsync);
  endfunction

  function automatic logic pulse(input int i, input int kind);
    return (kind == 0) ? ls[i] : fs[i];
  endfunction

  task automatic cmp_obs(input string name, input int i, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got %s exp %s", name, i, fmt(got), fmt(exp));
    end
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string name);
    for (int i = 0; i < 3; i++) cmp_obs(name, i, get_obs(i), model(cfg[i], e[i], adv[i]));
  endtask

  // One clock: advance the models with the inputs seen at the edge, then check all DUTs.
  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!clr_n_v[i]) begin
        e[i]   = 0;
        adv[i] = 1'b0;
      end else if (en_v[i]) begin
        e[i]++;
        adv[i] = (e[i] % cfg[i].div) == 0;
      end else begin
        adv[i] = 1'b0;
      end
    end
    #1;
    check_all("model");
  endtask

  // Asynchronous reset of one DUT, checked before the next clock edge.
  task automatic async_reset(input int i);
    clr_n_v[i] = 1'b0;
    e[i]       = 0;
    adv[i]     = 1'b0;
    #1;
    cmp_obs("async_reset", i, get_obs(i), model(cfg[i], e[i], adv[i]));
  endtask

  // Cycles between two consecutive line/frame pulses and active-cycle counts inside that span.
  task automatic measure(input int i, input int kind, output int period, output int hs_n,
                         output int vs_n, output int vo_n);
    bit ok;
    ok = 1'b0;
    period = 0; hs_n = 0; vs_n = 0; vo_n = 0;
    for (int k = 0; k < 5000; k++) begin
      if (pulse(i, kind)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    expect_int($sformatf("measure_start_dut%0d", i), int'(ok), 1);
    if (ok) begin
      do begin
        if (hs[i] == cfg[i].pol) hs_n++;
        if (vs[i] == cfg[i].pol) vs_n++;
        if (vo[i]) vo_n++;
        period++;
        tick();
      end while (!pulse(i, kind) && (period < 5000));
    end
  endtask

  vec_t tbl [9];

  initial begin
    int  per, hsn, vsn, von, n;
    bit  ok;

    total = 0; bad = 0; cyc = 0;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0};
    cfg[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0};
    cfg[2] = '{8, 2, 3, 2, 6, 1, 2, 1, 3, 1'b1};

    // First-pixel sequence for the DIV=2 instance: {clr_n, en, expected outputs after the edge}.
    tbl[0] = '{1'b0, 1'b1, mk(799, 524, 0, 0, 0, 0, 1, 1)};
    tbl[1] = '{1'b1, 1'b1, mk(799, 524, 0, 0, 0, 0, 1, 1)};
    tbl[2] = '{1'b1, 1'b1, mk(0,   0,   1, 1, 1, 1, 1, 1)};
    tbl[3] = '{1'b1, 1'b1, mk(0,   0,   0, 0, 0, 1, 1, 1)};
    tbl[4] = '{1'b1, 1'b1, mk(1,   0,   1, 0, 0, 1, 1, 1)};
    tbl[5] = '{1'b1, 1'b0, mk(1,   0,   0, 0, 0, 1, 1, 1)};
    tbl[6] = '{1'b1, 1'b0, mk(1,   0,   0, 0, 0, 1, 1, 1)};
    tbl[7] = '{1'b1, 1'b1, mk(1,   0,   0, 0, 0, 1, 1, 1)};
    tbl[8] = '{1'b1, 1'b1, mk(2,   0,   1, 0, 0, 1, 1, 1)};

    for (int i = 0; i < 3; i++) begin
      clr_n_v[i] = 1'b1;
      en_v[i]    = 1'b1;
      e[i]       = 0;
      adv[i]     = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) clr_n_v[i] = 1'b0;
    #1;
    check_all("reset_state");
    tick();
    tick();

    clr_n_v[1] = 1'b1;
    clr_n_v[2] = 1'b1;
    for (int r = 0; r < 9; r++) begin
      clr_n_v[0] = tbl[r].clr_n;
      en_v[0]    = tbl[r].en;
      tick();
      cmp_obs($sformatf("table[%0d]", r), 0, get_obs(0), tbl[r].exp);
    end

    // Run dut_a to x=300, hold with en low for 50 clocks, then resume.
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if ((xs[0] == 10'd300) && pt[0]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    expect_int("reach_x300", int'(ok), 1);
    en_v[0] = 1'b0;
    repeat (50) tick();
    expect_int("hold_x", int'(xs[0]), 300);
    expect_int("hold_y", int'(ys[0]), 0);
    en_v[0] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while ((xs[0] != 10'd301) && (n < 10));
    expect_int("resume_cycles_to_x301", n, 2);

    measure(0, 0, per, hsn, vsn, von);
    expect_int("a_line_period", per, 1600);
    expect_int("a_hsync_active_clk", hsn, 192);
    expect_int("a_video_on_clk", von, 1280);

    measure(1, 0, per, hsn, vsn, von);
    expect_int("b_line_period", per, 800);
    expect_int("b_hsync_active_clk", hsn, 96);
    expect_int("b_video_on_clk", von, 640);

    measure(2, 1, per, hsn, vsn, von);
    expect_int("c_frame_period", per, 450);
    expect_int("c_vsync_active_clk", vsn, 90);
    expect_int("c_hsync_active_clk", hsn, 90);
    expect_int("c_video_on_clk", von, 144);
    measure(2, 1, per, hsn, vsn, von);
    expect_int("c_frame_period_2", per, 450);

    // Mid-frame asynchronous reset of the DIV=1 instance, then restart at (0,0).
    ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if ((ys[1] == 10'd20) && (xs[1] == 10'd400)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    expect_int("reach_y20", int'(ok), 1);
    async_reset(1);
    expect_int("b_reset_x", int'(xs[1]), 799);
    expect_int("b_reset_y", int'(ys[1]), 524);
    tick();
    clr_n_v[1] = 1'b1;
    tick();
    expect_int("b_restart_frame_start", int'(fs[1]), 1);
    expect_int("b_restart_x", int'(xs[1]), 0);

    // Random enables on all instances with occasional resets of the small one.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) en_v[i] = ($urandom_range(0, 7) != 0);
      if (!clr_n_v[2]) clr_n_v[2] = 1'b1;
      else if ($urandom_range(0, 299) == 0) async_reset(2);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Sequences the VGA scan for the Pong display from the single system clock. It replaces the derived 25 MHz clock with a clock-enable (pix_tick), so all downstream logic stays on clk. From that enable it runs the horizontal and vertical scan counters and produces hsync, vsync, video_on, pixel coordinates and frame and line markers. It sits between the board clock and the Pong renderer and VGA pins.

Parameters:
DIV, 2, clk cycles per pixel (50 MHz clk -> 25 MHz pixel); legal range 1..16
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock
clr_n  in  1  asynchronous, active-low reset
en  in  1  run enable; low freezes all state
pix_tick  out  1  one-clk pulse marking the first cycle of each new pixel
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
video_on  out  1  high while (x,y) is inside the visible area
x  out  10  current horizontal position 0..H_TOTAL-1
y  out  10  current vertical position 0..V_TOTAL-1
line_start  out  1  one-clk pulse when x becomes 0
frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)

Behaviour:
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = sum of V_* (525). Both must be <= 1024, checked at elaboration.
- Reset (clr_n low, asynchronous): div_cnt=0, x=H_TOTAL-1 (799), y=V_TOTAL-1 (524). Outputs are pix_tick=0, line_start=0, frame_start=0, video_on=0, and hsync/vsync at the inactive level (~SYNC_POL).
- Divider: each clk with en=1, div_cnt increments. When div_cnt==DIV-1 it wraps to 0 and the scan advances by one pixel.
- Scan advance:
  - x increments; at x==H_TOTAL-1 it wraps to 0 and y increments.
  - When x wraps and y==V_TOTAL-1, y also wraps to 0.
- Output timing: all outputs are registered and decoded from next-state values, so they are aligned with x/y in the same cycle.
  - pix_tick=1 for exactly the first clk in which the new x/y is presented.
  - line_start=1 in that same clk when new x==0.
  - frame_start=1 in that same clk when new (x,y)==(0,0).
- Decodes:
  - video_on = (x<H_DISPLAY)&&(y<V_DISPLAY).
  - hsync active while H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vsync active while V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
- DIV=1: pix_tick stays high every clk while en=1.
- en low: div_cnt, x, y, hsync, vsync and video_on hold their values; pix_tick, line_start and frame_start are 0. Counting resumes from the held div_cnt.
- Reset mid-frame returns everything to reset values immediately. After clr_n deasserts with en=1, the first advance wraps to (0,0) and pulses frame_start.
- Pixel and line counts are exact: 800 pixels per line, 525 lines per frame, DIV*420000 clk per frame.

Decomposition:
- Shared package vga_timing_pkg holds the 640x480@60 constants (the H_*/V_* defaults), the derived H_TOTAL/V_TOTAL, and the coordinate width (10).
- One sub-module, pix_en_gen: parameter DIV; inputs clk, clr_n, en; output adv (advance strobe). It is the divider reworked to emit a clock-enable instead of a clock.
- Scan counters and decode stay in vga_timing_ctrl.

Test Plan:
- Reset state: hold clr_n=0 -> x=799, y=524, video_on=0, hsync=vsync=1, all pulses 0.
- First pixel: DIV=2, release clr_n with en=1 -> 2nd rising edge gives x=0, y=0, pix_tick=frame_start=line_start=1, video_on=1. 3rd edge gives pix_tick=0 with x still 0. 4th edge gives x=1.
- Line timing: run one line -> hsync low exactly for x=656..751 (96 pixels = 192 clk). video_on falls at x=640. line_start period = 1600 clk.
- Frame timing: run 2 frames -> vsync low only for y=490..491. frame_start period = 840000 clk. y wraps 524->0 together with x 799->0.
- en hold: drop en at x=300,y=100 for 50 clk -> x, y and syncs frozen, no pulses. Re-raise en -> next advance reaches x=301 after the remaining div_cnt cycles.
- DIV=1 and mid-frame reset: with DIV=1, pix_tick stays high continuously and the line is 800 clk. Asserting clr_n=0 at y=250 restores reset values asynchronously within the same cycle.
